bcd_scan_display: RTL and testbench

BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

---
 rtl/bcd_disp_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 16 +
 rtl/bcd_scan_display.sv | 196 +++++++++++++++++++
 tb/tb_bcd_scan_display.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared state type and 7-segment constants for the BCD scan display.
// Segment vectors are {g,f,e,d,c,b,a}, active-high.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  // Entry 0 sits in the LSBs.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
    7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-high {g,f,e,d,c,b,a}; non-decimal codes go dark.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i <= 4'd9) begin
      seg_o = SEG_TABLE[bcd_i];
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Serial double-dabble binary-to-BCD converter feeding a multiplexed 7-segment scanner.
// state | meaning: IDLE | await load ; SHIFT | one input bit per cycle ; DONE | commit result
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int BIN_W      = 8,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BIN_W-1:0]    bin_in,
  input  logic                load,
  input  logic                blank_lz,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg
);

  localparam int   BCD_W = 4 * DIGITS;
  localparam int   CNT_W = $clog2(BIN_W + 1);
  localparam int   IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int   PRE_W = $clog2(SCAN_DIV);
  localparam logic POL   = (ACTIVE_LOW != 0);

  conv_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [BCD_W-1:0] work_q, work_d, adj;
  logic             ovf_work_q, ovf_work_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic              presc_wrap;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d, an_act;
  logic [6:0]        seg_q, seg_d, seg_act, dec_seg;
  logic [3:0]        cur_digit;
  logic [DIGITS-1:0] blank_vec;
  logic              cur_blank;
  logic              zero_run;

  // ---------------- converter FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (load) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // ---------------- converter datapath ----------------
  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    work_d     = work_q;
    ovf_work_d = ovf_work_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          sr_d       = bin_in;
          work_d     = '0;
          ovf_work_d = 1'b0;
          cnt_d      = CNT_W'(BIN_W - 1);
        end
      end
      ST_SHIFT: begin
        // Whatever leaves the top digit is a value no longer representable.
        work_d     = {adj[BCD_W-2:0], sr_q[BIN_W-1]};
        ovf_work_d = ovf_work_q | adj[BCD_W-1];
        sr_d       = {sr_q[BIN_W-2:0], 1'b0};
        cnt_d      = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        bcd_d  = work_q;
        ovf_d  = ovf_work_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sr_q       <= '0;
      work_q     <= '0;
      ovf_work_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      work_q     <= work_d;
      ovf_work_q <= ovf_work_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

  // ---------------- display scan ----------------
  assign presc_wrap = (presc_q == PRE_W'(SCAN_DIV - 1));

  always_comb begin
    presc_d = presc_wrap ? '0 : presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_wrap) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (bcd_q[4*i +: 4] == 4'd0);
      blank_vec[i] = zero_run & (i != 0);
    end
  end

  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    an_act    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = bcd_q[4*i +: 4];
        cur_blank = blank_vec[i];
        an_act[i] = 1'b1;
      end
    end
  end

  seg7_decode u_seg7_decode (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    if (ovf_q)                      seg_act = SEG_DASH;
    else if (blank_lz && cur_blank) seg_act = SEG_BLANK;
    else                            seg_act = dec_seg;
    an_d  = an_act ^ {DIGITS{POL}};
    seg_d = seg_act ^ {7{POL}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= {DIGITS{POL}};
      seg_q   <= {7{POL}};
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: an 8-bit active-low and a 16-bit active-high instance
// share stimulus; a decimal-arithmetic model is compared every cycle, plus literal spot checks.
module tb_bcd_scan_display;

  localparam int D = 4;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] bin_in = '0;

  logic        busy8, done8, ovf8, busy16, done16, ovf16;
  logic [15:0] bcd8, bcd16;
  logic [3:0]  an8, an16;
  logic [6:0]  seg8, seg16;

  int n_tests = 0;
  int n_fail  = 0;

  int         m_k    [2];
  int         m_pend [2];
  int         m_val  [2];
  int         e_val  [2];
  logic       e_ovf  [2];
  logic       e_done [2];
  logic       e_busy [2];
  logic [3:0] e_an   [2];
  logic [6:0] e_seg  [2];
  logic       m_live = 1'b0;

  initial forever #5 clk = ~clk;

  bcd_scan_display #(.BIN_W(8), .DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in[7:0]), .load(load), .blank_lz(blank_lz),
    .busy(busy8), .done(done8), .bcd_out(bcd8), .overflow(ovf8), .an(an8), .seg(seg8)
  );

  bcd_scan_display #(.BIN_W(16), .DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(0)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load), .blank_lz(blank_lz),
    .busy(busy16), .done(done16), .bcd_out(bcd16), .overflow(ovf16), .an(an16), .seg(seg16)
  );

  function automatic int p10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // What digit i of a committed value should look like (active-high).
  function automatic logic [6:0] face(input int v, input logic ovf, input logic blz, input int i);
    if (ovf) return 7'h40;
    if (blz && i > 0 && v < p10(i)) return 7'h00;
    return glyph((v / p10(i)) % 10);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  function automatic logic [3:0] cur_an(input int u);
    return (u == 0) ? an8 : an16;
  endfunction

  // Model: k = clock edges since reset; a load takes BIN_W+1 edges to commit.
  initial begin : model
    int idx;
    int bw;
    logic al;
    logic [3:0] an_on;
    logic [6:0] seg_on;
    forever begin
      @(posedge clk);
      for (int u = 0; u < 2; u++) begin
        bw = (u == 0) ? 8 : 16;
        al = (u == 0);
        if (!rst_n) begin
          m_k[u]    = 0;
          m_pend[u] = 0;
          m_val[u]  = 0;
          e_val[u]  = 0;
          e_ovf[u]  = 1'b0;
          e_done[u] = 1'b0;
          e_busy[u] = 1'b0;
          e_an[u]   = al ? 4'hF : 4'h0;
          e_seg[u]  = al ? 7'h7F : 7'h00;
        end else begin
          idx    = (m_k[u] / S) % D;
          an_on  = 4'(1 << idx);
          seg_on = face(e_val[u], e_ovf[u], blank_lz, idx);
          e_an[u]  = al ? ~an_on : an_on;
          e_seg[u] = al ? ~seg_on : seg_on;
          m_k[u]++;
          e_done[u] = 1'b0;
          if (m_pend[u] > 0) begin
            m_pend[u]--;
            if (m_pend[u] == 0) begin
              e_val[u]  = m_val[u] % p10(D);
              e_ovf[u]  = (m_val[u] > p10(D) - 1);
              e_done[u] = 1'b1;
            end
          end else if (load) begin
            m_pend[u] = bw + 1;
            m_val[u]  = (u == 0) ? int'(bin_in[7:0]) : int'(bin_in);
          end
          e_busy[u] = (m_pend[u] > 0);
        end
      end
      m_live = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("busy8",  32'(busy8),  32'(e_busy[0]));
        chk("done8",  32'(done8),  32'(e_done[0]));
        chk("bcd8",   32'(bcd8),   32'(to_bcd(e_val[0])));
        chk("ovf8",   32'(ovf8),   32'(e_ovf[0]));
        chk("an8",    32'(an8),    32'(e_an[0]));
        chk("seg8",   32'(seg8),   32'(e_seg[0]));
        chk("busy16", 32'(busy16), 32'(e_busy[1]));
        chk("done16", 32'(done16), 32'(e_done[1]));
        chk("bcd16",  32'(bcd16),  32'(to_bcd(e_val[1])));
        chk("ovf16",  32'(ovf16),  32'(e_ovf[1]));
        chk("an16",   32'(an16),   32'(e_an[1]));
        chk("seg16",  32'(seg16),  32'(e_seg[1]));
      end
    end
  endtask

  task automatic load_val(input int v);
    bin_in = 16'(v);
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic wait_done(input int u, output int lat);
    lat = 0;
    while (!((u == 0) ? done8 : done16) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic idle_both();
    int n;
    n = 0;
    while ((busy8 || busy16) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(busy8 | busy16), 32'd0);
  endtask

  task automatic scan_lit(input int u, input int i, input logic [6:0] exp_seg);
    logic [3:0] tgt;
    int n;
    tgt = 4'(1 << i);
    if (u == 0) tgt = ~tgt;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cur_an(u) != tgt && n < 40);
    chk($sformatf("scan_an_u%0d_d%0d", u, i), 32'(cur_an(u)), 32'(tgt));
    chk($sformatf("scan_seg_u%0d_d%0d", u, i), 32'((u == 0) ? seg8 : seg16), 32'(exp_seg));
  endtask

  task automatic walk(input int u);
    logic [3:0] t0, t1, t3;
    int n, hold;
    t0 = (u == 0) ? 4'b1110 : 4'b0001;
    t1 = (u == 0) ? 4'b1101 : 4'b0010;
    t3 = (u == 0) ? 4'b0111 : 4'b1000;
    n = 0;
    while (cur_an(u) != t3 && n < 40) begin @(negedge clk); n++; end
    while (cur_an(u) != t0 && n < 40) begin @(negedge clk); n++; end
    hold = 0;
    while (cur_an(u) == t0 && hold < 20) begin @(negedge clk); hold++; end
    chk($sformatf("hold_u%0d", u), 32'(hold), 32'd4);
    chk($sformatf("next_u%0d", u), 32'(cur_an(u)), 32'(t1));
  endtask

  task automatic run();
    int lat, nd;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an8",  32'(an8),  32'h0F);
    chk("rst_seg8", 32'(seg8), 32'h7F);
    chk("rst_an16", 32'(an16), 32'h0);
    chk("rst_bcd8", 32'(bcd8), 32'h0);
    rst_n = 1'b1;

    walk(0);
    walk(1);

    // 255 -> 0x0255, displayed 5,5,2,blank
    blank_lz = 1'b1;
    idle_both();
    load_val(255);
    wait_done(0, lat);
    chk("lat255", 32'(lat), 32'd9);
    chk("bcd255", 32'(bcd8), 32'h0255);
    chk("ovf255", 32'(ovf8), 32'd0);
    scan_lit(0, 0, 7'h12);
    scan_lit(0, 1, 7'h12);
    scan_lit(0, 2, 7'h24);
    scan_lit(0, 3, 7'h7F);

    // zero with and without leading-zero blanking
    idle_both();
    load_val(0);
    wait_done(0, lat);
    chk("bcd0", 32'(bcd8), 32'h0);
    idle_both();
    scan_lit(0, 0, 7'h40);
    scan_lit(0, 1, 7'h7F);
    scan_lit(0, 3, 7'h7F);
    scan_lit(1, 0, 7'h3F);
    scan_lit(1, 2, 7'h00);
    blank_lz = 1'b0;
    scan_lit(0, 1, 7'h40);
    scan_lit(0, 2, 7'h40);
    scan_lit(0, 3, 7'h40);
    scan_lit(1, 3, 7'h3F);

    // 16-bit overflow shows dashes everywhere, then 9999 fits
    blank_lz = 1'b1;
    idle_both();
    load_val(12345);
    wait_done(1, lat);
    chk("lat12345", 32'(lat), 32'd17);
    chk("ovf12345", 32'(ovf16), 32'd1);
    for (int i = 0; i < D; i++) scan_lit(1, i, 7'h40);
    idle_both();
    load_val(9999);
    wait_done(1, lat);
    chk("bcd9999", 32'(bcd16), 32'h9999);
    chk("ovf9999", 32'(ovf16), 32'd0);
    scan_lit(1, 3, 7'h6F);

    // load during SHIFT is dropped
    idle_both();
    load_val(37);
    repeat (3) @(negedge clk);
    load_val(200);
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("one_done", 32'(nd), 32'd1);
    chk("bcd37", 32'(bcd8), 32'h0037);

    // reset in the middle of a conversion
    idle_both();
    load_val(200);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_bcd", 32'(bcd8), 32'h0);
    chk("mid_rst_an",  32'(an8),  32'h0F);
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_rst", 32'(bcd8), 32'h0);
    load_val(142);
    wait_done(0, lat);
    chk("lat142", 32'(lat), 32'd9);
    chk("bcd142", 32'(bcd8), 32'h0142);
    idle_both();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
      run();
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
